stream_pattern_producer: RTL and testbench

Upstream source stage for the 32-bit valid/ready stream consumed by the PoC stream sink. On a start command it emits a programmable arithmetic sequence of words (base, base+stride, ...), len beats long, and marks the final beat with last. It honours downstream backpressure, keeps a running checksum of accepted beats, and pulses done at end of burst. The bench uses it as a stimulus generator for the handshake path.

---
 rtl/stream_pattern_producer.sv | 98 +++++++++
 tb/tb_stream_pattern_producer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_pattern_producer.sv
// rtl/stream_pattern_producer.sv - arithmetic-sequence burst source for a 32-bit valid/ready stream
module stream_pattern_producer #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] stride,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              vld,
  input  logic              rdy,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic [LEN_W-1:0]  beat_count,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] stride_r;
  logic [LEN_W-1:0]  len_r;

  // Count after the beat currently on the bus is accepted; drives the
  // look-ahead for last so it is ready with the following word.
  logic [LEN_W-1:0]  beat_next;
  logic              xfer;

  assign beat_next = beat_count + LEN_ONE;
  assign xfer      = vld & rdy;

  // Burst sequencer: all outputs are registered; vld is raised without
  // looking at rdy and only dropped after the final beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      stride_r   <= '0;
      len_r      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vld        <= 1'b0;
      data       <= '0;
      last       <= 1'b0;
      beat_count <= '0;
      checksum   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            beat_count <= '0;
            checksum   <= '0;
            if (len != '0) begin
              stride_r <= stride;
              len_r    <= len;
              data     <= base;
              vld      <= 1'b1;
              last     <= (len == LEN_ONE);
              busy     <= 1'b1;
              state    <= RUN;
            end else begin
              // Empty burst: nothing to send, just signal completion.
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            beat_count <= beat_next;
            checksum   <= checksum + data;
            if (last) begin
              // Final word stays on data for observation after the burst.
              vld   <= 1'b0;
              last  <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              data <= data + stride_r;
              last <= (beat_next == (len_r - LEN_ONE));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pattern_producer.sv
// tb/tb_stream_pattern_producer.sv - directed self-checking bench for stream_pattern_producer
module tb_stream_pattern_producer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base;
  logic [31:0] stride;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        vld;
  logic        rdy;
  logic [31:0] data;
  logic        last;
  logic [15:0] beat_count;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;

  stream_pattern_producer #(.DATA_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .stride(stride),
    .len(len), .busy(busy), .done(done), .vld(vld), .rdy(rdy), .data(data),
    .last(last), .beat_count(beat_count), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] b, input logic [31:0] s, input logic [15:0] l);
    base = b; stride = s; len = l; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_end(input string tag, input logic [15:0] cnt, input logic [31:0] sum);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_vld"},  32'(vld),  32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cnt"},  32'(beat_count), 32'(cnt));
    check({tag, "_sum"},  checksum, sum);
  endtask

  logic [31:0] bp_data [6];
  logic        bp_rdy  [6];
  logic        bp_last [6];

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; stride = '0; len = '0; rdy = 1'b0;
    step(); step();
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_cnt", 32'(beat_count), 32'd0);
    check("rst_sum", checksum, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic burst, rdy always high
    rdy = 1'b1;
    launch(32'h1000, 32'd4, 16'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_vld%0d", i), 32'(vld), 32'd1);
      check($sformatf("basic_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("basic_data%0d", i), data, 32'h1000 + 32'(4 * i));
      check($sformatf("basic_last%0d", i), 32'(last), (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    check_end("basic", 16'd4, 32'h4018);
    check("basic_hold", data, 32'h100C);
    step();
    check("basic_done_pulse", 32'(done), 32'd0);

    // Backpressure: rdy 0,1,0,0,1,1 from first vld
    bp_rdy  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bp_data = '{32'hA0, 32'hA0, 32'hA1, 32'hA1, 32'hA1, 32'hA2};
    bp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rdy = 1'b0;
    launch(32'hA0, 32'd1, 16'd3);
    for (int i = 0; i < 6; i++) begin
      rdy = bp_rdy[i];
      check($sformatf("bp_vld%0d", i), 32'(vld), 32'd1);
      check($sformatf("bp_data%0d", i), data, bp_data[i]);
      check($sformatf("bp_last%0d", i), 32'(last), 32'(bp_last[i]));
      if (i == 3) check("bp_cnt_mid", 32'(beat_count), 32'd1);
      step();
    end
    check_end("bp", 16'd3, 32'h1E3);
    step();

    // Sink-style: rdy rises one cycle after vld is seen
    rdy = 1'b0;
    launch(32'h55, 32'h10, 16'd2);
    check("sink_vld_no_rdy", 32'(vld), 32'd1);
    check("sink_data0", data, 32'h55);
    step();
    check("sink_vld_held", 32'(vld), 32'd1);
    check("sink_data_held", data, 32'h55);
    check("sink_cnt_held", 32'(beat_count), 32'd0);
    rdy = 1'b1;
    step();
    check("sink_data1", data, 32'h65);
    check("sink_last1", 32'(last), 32'd1);
    step();
    check_end("sink", 16'd2, 32'hBA);
    step();

    // Wrap-around of data and checksum
    launch(32'hFFFFFFFE, 32'd1, 16'd3);
    check("wrap_d0", data, 32'hFFFFFFFE);
    step();
    check("wrap_d1", data, 32'hFFFFFFFF);
    step();
    check("wrap_d2", data, 32'h00000000);
    check("wrap_last", 32'(last), 32'd1);
    step();
    check_end("wrap", 16'd3, 32'hFFFFFFFD);
    step();

    // Single-beat burst
    launch(32'h77, 32'd5, 16'd1);
    check("len1_vld", 32'(vld), 32'd1);
    check("len1_last", 32'(last), 32'd1);
    check("len1_data", data, 32'h77);
    step();
    check_end("len1", 16'd1, 32'h77);
    step();

    // Zero-length burst
    launch(32'h1234, 32'd1, 16'd0);
    check_end("len0", 16'd0, 32'd0);
    step();
    check("len0_pulse", 32'(done), 32'd0);
    check("len0_novld", 32'(vld), 32'd0);

    // Start mid-burst is ignored; start on the done cycle is accepted
    launch(32'h200, 32'd2, 16'd3);
    check("race_d0", data, 32'h200);
    base = 32'h999; stride = 32'd7; len = 16'd9; start = 1'b1;
    step();
    start = 1'b0;
    check("race_d1", data, 32'h202);
    check("race_busy", 32'(busy), 32'd1);
    step();
    check("race_d2", data, 32'h204);
    check("race_last", 32'(last), 32'd1);
    step();
    check_end("race", 16'd3, 32'h606);
    launch(32'h300, 32'd1, 16'd2);
    check("b2b_vld", 32'(vld), 32'd1);
    check("b2b_d0", data, 32'h300);
    check("b2b_cnt_clr", 32'(beat_count), 32'd0);
    step();
    check("b2b_d1", data, 32'h301);
    step();
    check_end("b2b", 16'd2, 32'h601);
    step();

    // Reset mid-burst after two accepted beats
    launch(32'h10, 32'd1, 16'd5);
    step();
    step();
    check("mid_cnt_pre", 32'(beat_count), 32'd2);
    check("mid_data_pre", data, 32'h12);
    rst_n = 1'b0;
    #1;
    check("mid_vld", 32'(vld), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_cnt", 32'(beat_count), 32'd0);
    check("mid_sum", checksum, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_done", 32'(done), 32'd0);
    launch(32'h40, 32'd3, 16'd2);
    check("post_d0", data, 32'h40);
    step();
    check("post_d1", data, 32'h43);
    check("post_last", 32'(last), 32'd1);
    step();
    check_end("post", 16'd2, 32'h83);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
